// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared states, word-length codes and helpers for the UART receiver
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 4'd5;
      WLS_6:   return 4'd6;
      WLS_7:   return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_sync.sv
// ============================================================================
// Module   : uart_bit_sync
// Purpose  : Flop-chain synchroniser for one asynchronous bit, resets to 1
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  if (STAGES == 1) begin : g_single
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_chain <= '1;
      end else begin
        r_chain <= i_d;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_chain <= '1;
      end else begin
        r_chain <= {r_chain[STAGES-2:0], i_d};
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
// ============================================================================
// Module   : uart_rx_deserializer
// Purpose  : 16x-oversampled UART receive front end feeding the RX FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       wr_clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_wr,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       oe,
  output logic       busy
);

  localparam int            CW          = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_FULL_LAST = CW'(OVERSAMPLE - 1);

  rx_state_t     r_state;
  rx_state_t     w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_acc;
  logic          r_par_bit;
  logic          r_pe_int;
  logic [1:0]    r_wls;
  logic          r_pen;
  logic          r_eps;
  logic          r_sp;

  logic w_rxs;
  logic w_half;
  logic w_full;
  logic w_clr_cnt;
  logic w_load_cfg;
  logic w_shift;
  logic w_par_sample;
  logic w_stop_sample;
  logic w_last_bit;
  logic w_par_exp;
  logic w_break;

  uart_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (wr_clk),
    .reset (reset),
    .i_d   (rx_in),
    .o_q   (w_rxs)
  );

  assign w_half     = baud_tick && (r_cnt == C_HALF_LAST);
  assign w_full     = baud_tick && (r_cnt == C_FULL_LAST);
  assign w_last_bit = ({1'b0, r_bit_cnt} == (data_bits(r_wls) - 4'd1));
  assign w_par_exp  = r_sp ? ~r_eps : (r_eps ? r_par_acc : ~r_par_acc);
  // Break: every sampled bit of the frame, including the stop bit, was 0.
  assign w_break    = (r_shift == 8'h00) && !(r_pen && r_par_bit) && !w_rxs;
  assign busy       = (r_state != IDLE);

  always_ff @(posedge wr_clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_clr_cnt     = 1'b0;
    w_load_cfg    = 1'b0;
    w_shift       = 1'b0;
    w_par_sample  = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      IDLE: begin
        if (baud_tick && !w_rxs) begin
          w_next    = START;
          w_clr_cnt = 1'b1;
        end
      end
      START: begin
        if (w_half) begin
          if (!w_rxs) begin
            w_next     = DATA;
            w_clr_cnt  = 1'b1;
            w_load_cfg = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      DATA: begin
        if (w_full) begin
          w_shift = 1'b1;
          if (w_last_bit) begin
            w_next = r_pen ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_full) begin
          w_par_sample = 1'b1;
          w_next       = STOP;
        end
      end
      STOP: begin
        if (w_full) begin
          w_stop_sample = 1'b1;
          w_next        = w_break ? BREAK_WAIT : IDLE;
        end
      end
      BREAK_WAIT: begin
        if (baud_tick && w_rxs) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter wraps explicitly so non-power-of-two oversample ratios still work.
  always_ff @(posedge wr_clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_clr_cnt) begin
      r_cnt <= '0;
    end else if (baud_tick) begin
      r_cnt <= (r_cnt == C_FULL_LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge wr_clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par_acc <= 1'b0;
      r_par_bit <= 1'b0;
      r_pe_int  <= 1'b0;
      r_wls     <= WLS_5;
      r_pen     <= 1'b0;
      r_eps     <= 1'b0;
      r_sp      <= 1'b0;
    end else begin
      if (w_load_cfg) begin
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'h00;
        r_par_acc <= 1'b0;
        r_par_bit <= 1'b0;
        r_pe_int  <= 1'b0;
        r_wls     <= wls;
        r_pen     <= pen;
        r_eps     <= eps;
        r_sp      <= sp;
      end
      if (w_shift) begin
        r_shift[r_bit_cnt] <= w_rxs;
        r_par_acc          <= r_par_acc ^ w_rxs;
        r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
      if (w_par_sample) begin
        r_par_bit <= w_rxs;
        r_pe_int  <= (w_rxs != w_par_exp);
      end
    end
  end

  always_ff @(posedge wr_clk or negedge reset) begin
    if (!reset) begin
      rx_data <= 8'h00;
      rx_wr   <= 1'b0;
      pe      <= 1'b0;
      fe      <= 1'b0;
      bi      <= 1'b0;
      oe      <= 1'b0;
    end else begin
      rx_wr <= 1'b0;
      oe    <= 1'b0;
      if (w_stop_sample) begin
        if (fifo_full) begin
          oe <= 1'b1;
        end else begin
          rx_wr   <= 1'b1;
          rx_data <= w_break ? 8'h00 : r_shift;
          pe      <= r_pe_int;
          fe      <= ~w_rxs;
          bi      <= w_break;
        end
      end
    end
  end

endmodule

`default_nettype wire
